// File: rtl/score_bcd_display.sv
// Binary score to six-digit BCD converter (sequential double-dabble, one bit per clock)
// driving six active-low 7-segment displays; outputs change only on completed conversions.
module score_bcd_display #(
    parameter int SCORE_W       = 24,
    parameter int SAT_MAX       = 999999,
    parameter int BLANK_LEADING = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [SCORE_W-1:0] score,
    output logic [23:0]        bcd_out,
    output logic               busy,
    output logic               overflow,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5
);

    localparam int                 CNT_W     = $clog2(SCORE_W);
    localparam logic [SCORE_W-1:0] SAT_VAL   = SCORE_W'(SAT_MAX);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(SCORE_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [23:0]        digits_q, digits_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [23:0]        bcd_q, bcd_d;
    logic [23:0]        adj;

    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        bin_d        = bin_q;
        digits_d     = digits_q;
        count_d      = count_q;
        sat_d        = sat_q;
        busy_d       = busy_q;
        overflow_d   = overflow_q;
        bcd_d        = bcd_q;
        adj          = '0;

        for (int i = 0; i < 6; i++) begin
            adj[4*i +: 4] = (digits_q[4*i +: 4] >= 4'd5) ? digits_q[4*i +: 4] + 4'd3
                                                         : digits_q[4*i +: 4];
        end

        case (state_q)
            IDLE: begin
                if (score != last_score_q) begin
                    last_score_d = score;
                    sat_d        = (score > SAT_VAL);
                    bin_d        = (score > SAT_VAL) ? SAT_VAL : score;
                    digits_d     = '0;
                    count_d      = '0;
                    busy_d       = 1'b1;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                {digits_d, bin_d} = {adj, bin_q} << 1;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bcd_d      = digits_q;
                overflow_d = sat_q;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_score_q <= '0;
            bin_q        <= '0;
            digits_q     <= '0;
            count_q      <= '0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            bcd_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            bin_q        <= bin_d;
            digits_q     <= digits_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            bcd_q        <= bcd_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [6:0] seg [6];
    logic       upper_zero;

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 5; k >= 0; k--) begin
            upper_zero = upper_zero && (bcd_q[4*k +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (k != 0) && upper_zero) begin
                seg[k] = 7'b1111111;
            end else begin
                seg[k] = seg7(bcd_q[4*k +: 4]);
            end
        end
    end

    assign bcd_out  = bcd_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign hex0     = seg[0];
    assign hex1     = seg[1];
    assign hex2     = seg[2];
    assign hex3     = seg[3];
    assign hex4     = seg[4];
    assign hex5     = seg[5];

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench for score_bcd_display: directed scenarios plus random scores,
// compared against a decimal-arithmetic reference model.
module tb_score_bcd_display;

    logic        clock = 1'b0;
    logic        reset_n, reset_n2;
    logic [23:0] score, score2;
    logic [23:0] bcd_out, bcd_out2;
    logic        busy, busy2, overflow, overflow2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  h0b, h1b, h2b, h3b, h4b, h5b;

    int checks   = 0;
    int failures = 0;
    int cur_score = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clock = ~clock;

    score_bcd_display dut (
        .clock(clock), .reset_n(reset_n), .score(score), .bcd_out(bcd_out), .busy(busy),
        .overflow(overflow), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5)
    );

    score_bcd_display #(.BLANK_LEADING(0)) dut_nb (
        .clock(clock), .reset_n(reset_n2), .score(score2), .bcd_out(bcd_out2), .busy(busy2),
        .overflow(overflow2), .hex0(h0b), .hex1(h1b), .hex2(h2b), .hex3(h3b),
        .hex4(h4b), .hex5(h5b)
    );

    function automatic int clamp(input int v);
        return (v > 999999) ? 999999 : v;
    endfunction

    function automatic logic [23:0] exp_bcd(input int v);
        logic [23:0] r = '0;
        int c = clamp(v);
        int p = 1;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'((c / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [41:0] exp_hex(input int v, input bit blank);
        logic [41:0] r = '0;
        int c = clamp(v);
        int p = 1;
        for (int k = 0; k < 6; k++) begin
            if (blank && k > 0 && c < p) r[7*k +: 7] = 7'b1111111;
            else                         r[7*k +: 7] = seg_tab[(c / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic convert_and_check(input int v, input string name);
        logic [23:0] old_bcd;
        int bad_busy;
        int bad_hold;
        old_bcd  = bcd_out;
        bad_busy = 0;
        bad_hold = 0;
        score = 24'(v);
        repeat (25) begin
            @(negedge clock);
            if (busy !== 1'b1) bad_busy++;
            if (bcd_out !== old_bcd) bad_hold++;
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("[TB] FAIL %s busy_window: %0d cycles low, required 0", name, bad_busy);
        end
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("[TB] FAIL %s bcd_hold: changed in %0d cycles, required 0", name, bad_hold);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s busy_done: got %b required 0", name, busy);
        end
        checks++;
        if (bcd_out !== exp_bcd(v)) begin
            failures++;
            $display("[TB] FAIL %s bcd: got %h required %h", name, bcd_out, exp_bcd(v));
        end
        checks++;
        if (overflow !== (v > 999999)) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %b required %b", name, overflow, v > 999999);
        end
        checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(v, 1'b1)) begin
            failures++;
            $display("[TB] FAIL %s hex: got %h required %h", name,
                     {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(v, 1'b1));
        end
        cur_score = v;
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        reset_n  = 1'b0;
        reset_n2 = 1'b0;
        score    = '0;
        score2   = '0;
        repeat (3) @(negedge clock);
        reset_n  = 1'b1;
        reset_n2 = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            failures++;
            $display("[TB] FAIL reset_busy: high %0d cycles, required 0", busy_seen);
        end
        checks++;
        if (bcd_out !== 24'h0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_bcd: got %h/%b required 000000/0", bcd_out, overflow);
        end
        checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(0, 1'b1)) begin
            failures++;
            $display("[TB] FAIL reset_hex: got %h required %h",
                     {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(0, 1'b1));
        end
        cur_score = 0;
    endtask

    task automatic test_basic();
        convert_and_check(1234, "step_1234");
    endtask

    task automatic test_clamp();
        convert_and_check(999999, "max_inrange");
        convert_and_check(16777215, "clamp_full");
        convert_and_check(1000000, "clamp_edge");
        convert_and_check(100, "clamp_clear");
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 14; i++) begin
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 24'hFFFFFF));
            else                           v = int'($urandom_range(0, 999999));
            if (v == cur_score) v = (v + 1) % 16777216;
            convert_and_check(v, "random");
        end
    endtask

    task automatic test_back_to_back();
        int busy_seen = 0;
        convert_and_check(10, "b2b_pre");
        score = 24'd20;
        repeat (5) @(negedge clock);
        score = 24'd30;
        repeat (21) @(negedge clock);
        checks++;
        if (bcd_out !== 24'h000020 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h/%b required 000020/0", bcd_out, busy);
        end
        repeat (4) @(negedge clock);
        score = 24'd88;
        repeat (5) @(negedge clock);
        score = 24'd30;
        repeat (16) @(negedge clock);
        checks++;
        if (bcd_out !== 24'h000020 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_inflight: got %h/%b required 000020/1", bcd_out, busy);
        end
        @(negedge clock);
        checks++;
        if (bcd_out !== 24'h000030 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h/%b required 000030/0", bcd_out, busy);
        end
        repeat (30) begin
            @(negedge clock);
            if (busy !== 1'b0 || bcd_out !== 24'h000030) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) begin
            failures++;
            $display("[TB] FAIL b2b_revert: %0d disturbed cycles, required 0", busy_seen);
        end
        cur_score = 30;
    endtask

    task automatic test_reset_mid();
        int bad_busy = 0;
        score = 24'd555555;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || bcd_out !== 24'h0 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_state: got %b/%h/%b required 0/000000/0",
                     busy, bcd_out, overflow);
        end
        checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== exp_hex(0, 1'b1)) begin
            failures++;
            $display("[TB] FAIL midreset_hex: got %h required %h",
                     {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex(0, 1'b1));
        end
        reset_n = 1'b1;
        repeat (25) begin
            @(negedge clock);
            if (busy !== 1'b1) bad_busy++;
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("[TB] FAIL midreset_restart: busy low %0d cycles, required 0", bad_busy);
        end
        @(negedge clock);
        checks++;
        if (bcd_out !== exp_bcd(555555) || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_result: got %h/%b required %h/0",
                     bcd_out, busy, exp_bcd(555555));
        end
        cur_score = 555555;
    endtask

    task automatic test_no_blank();
        checks++;
        if ({h5b, h4b, h3b, h2b, h1b, h0b} !== exp_hex(0, 1'b0)) begin
            failures++;
            $display("[TB] FAIL noblank_reset: got %h required %h",
                     {h5b, h4b, h3b, h2b, h1b, h0b}, exp_hex(0, 1'b0));
        end
        score2 = 24'd7;
        repeat (26) @(negedge clock);
        checks++;
        if (bcd_out2 !== 24'h000007 || {h5b, h4b, h3b, h2b, h1b, h0b} !== exp_hex(7, 1'b0)) begin
            failures++;
            $display("[TB] FAIL noblank_7: got %h/%h required 000007/%h", bcd_out2,
                     {h5b, h4b, h3b, h2b, h1b, h0b}, exp_hex(7, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_no_blank();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
